// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV32I decode stage driving ALU op/operands; ALU_DECODE_SKID_EN adds a 1-entry skid buffer
module alu_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal
);

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Bundle layout: {alu_op, op_a, op_b, rd_addr, rd_we, illegal}
  localparam int BW = 4 + XLEN + XLEN + 5 + 1 + 1;

  logic [6:0]      w_opcode;
  logic [2:0]      w_funct3;
  logic [6:0]      w_funct7;
  logic [4:0]      w_rd;
  logic [XLEN-1:0] w_imm_i;
  logic [XLEN-1:0] w_imm_u;
  logic [XLEN-1:0] w_shamt_r;
  logic [XLEN-1:0] w_shamt_i;
  logic [3:0]      w_op;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic            w_ill;
  logic [BW-1:0]   w_bundle;

  logic            r_out_valid;
  logic [BW-1:0]   r_out_bundle;

  assign w_opcode  = instr[6:0];
  assign w_funct3  = instr[14:12];
  assign w_funct7  = instr[31:25];
  assign w_rd      = instr[11:7];
  assign w_imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign w_imm_u   = {instr[31:12], 12'b0};
  // The ALU uses all operand bits as shift amount, so only the low five may pass
  assign w_shamt_r = {{(XLEN-5){1'b0}}, rs2_data[4:0]};
  assign w_shamt_i = {{(XLEN-5){1'b0}}, instr[24:20]};

  // Decode the presented instruction into ALU op, operands and legality
  always_comb begin
    w_op  = ALU_ADD;
    w_a   = '0;
    w_b   = '0;
    w_ill = 1'b0;
    case (w_opcode)
      OPC_OP, OPC_OP_IMM: begin
        w_a = rs1_data;
        w_b = (w_opcode == OPC_OP) ? rs2_data : w_imm_i;
        case (w_funct3)
          3'b000: begin
            if (w_opcode == OPC_OP_IMM || w_funct7 == F7_ZERO) w_op = ALU_ADD;
            else if (w_funct7 == F7_ALT) w_op = ALU_SUB;
            else w_ill = 1'b1;
          end
          3'b001: begin
            w_op  = ALU_SLL;
            w_b   = (w_opcode == OPC_OP) ? w_shamt_r : w_shamt_i;
            w_ill = (w_funct7 != F7_ZERO);
          end
          3'b101: begin
            w_b = (w_opcode == OPC_OP) ? w_shamt_r : w_shamt_i;
            if (w_funct7 == F7_ZERO) w_op = ALU_SRL;
            else if (w_funct7 == F7_ALT) w_op = ALU_SRA;
            else w_ill = 1'b1;
          end
          default: begin
            case (w_funct3)
              3'b010:  w_op = ALU_SLT;
              3'b011:  w_op = ALU_SLTU;
              3'b100:  w_op = ALU_XOR;
              3'b110:  w_op = ALU_OR;
              default: w_op = ALU_AND;
            endcase
            // For OP-IMM the funct7 field is immediate bits, not an opcode extension
            w_ill = (w_opcode == OPC_OP) && (w_funct7 != F7_ZERO);
          end
        endcase
      end
      OPC_LUI: begin
        w_b = w_imm_u;
      end
      OPC_AUIPC: begin
        w_a = pc;
        w_b = w_imm_u;
      end
      default: begin
        w_ill = 1'b1;
      end
    endcase
    if (w_ill) begin
      w_op = ALU_ADD;
      w_a  = '0;
      w_b  = '0;
    end
  end

  assign w_bundle = {w_op, w_a, w_b, w_rd, (!w_ill && (w_rd != 5'd0)), w_ill};

`ifdef ALU_DECODE_SKID_EN
  logic          r_skid_valid;
  logic [BW-1:0] r_skid_bundle;
  logic          w_in_fire;

  // in_ready comes straight from the skid flop, breaking the out_ready timing path
  assign in_ready  = !r_skid_valid;
  assign w_in_fire = in_valid && in_ready;

  // Output register refills from the skid entry first so ordering is preserved
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_bundle  <= '0;
      r_skid_valid  <= 1'b0;
      r_skid_bundle <= '0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_valid) begin
        r_out_bundle <= r_skid_bundle;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out_bundle <= w_bundle;
        r_out_valid  <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_bundle <= w_bundle;
      r_skid_valid  <= 1'b1;
    end
  end
`else
  assign in_ready = !r_out_valid || out_ready;

  // Single output register: load whenever it is empty or being drained
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_bundle <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (!r_out_valid || out_ready) begin
      r_out_valid <= in_valid;
      if (in_valid) r_out_bundle <= w_bundle;
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign {alu_op, op_a, op_b, rd_addr, rd_we, illegal} = r_out_bundle;

endmodule
